// File: rtl/auto_freq_pkg.sv
// Shared definitions for the auto frequency controller: FSM encoding,
// parameter defaults and result widths.
package auto_freq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        MEAS = 3'd2,
        DIV  = 3'd3,
        CONV = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam int CLK_MS_COUNT_DEF = 50000;
    localparam int TIMEOUT_MS_DEF   = 2000;
    localparam int DVND_DEF         = 1000;

    localparam int FREQ_W = 10;
    localparam int BCD_W  = 16;
    localparam int DIV_W  = 20;

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond counter: counts 0..CLK_MS_COUNT-1 while enabled
// and flags the wrap cycle on tick.
module ms_tick_gen
    import auto_freq_pkg::*;
#(
    parameter int CLK_MS_COUNT = CLK_MS_COUNT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (CLK_MS_COUNT > 1) ? $clog2(CLK_MS_COUNT) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_MS_COUNT - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset || clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/auto_freq_ctrl.sv
// Sequences period measurement, DVND/period division and binary-to-BCD
// conversion, with a millisecond timeout on the period measurement.
module auto_freq_ctrl
    import auto_freq_pkg::*;
#(
    parameter int CLK_MS_COUNT = CLK_MS_COUNT_DEF,
    parameter int TIMEOUT_MS   = TIMEOUT_MS_DEF,
    parameter int DVND         = DVND_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                prd_ready,
    input  logic                prd_done_tick,
    input  logic [FREQ_W-1:0]   prd,
    output logic                prd_start,
    input  logic                div_ready,
    input  logic                div_done_tick,
    input  logic [DIV_W-1:0]    quo,
    output logic                div_start,
    output logic [DIV_W-1:0]    dvsr,
    output logic [DIV_W-1:0]    dvnd,
    input  logic                b2b_ready,
    input  logic                b2b_done_tick,
    input  logic [BCD_W-1:0]    bcd,
    output logic                b2b_start,
    output logic [FREQ_W-1:0]   bin,
    output logic                ready,
    output logic                done_tick,
    output logic                err,
    output logic [FREQ_W-1:0]   freq,
    output logic [BCD_W-1:0]    freq_bcd
);

    localparam int TO_W = (TIMEOUT_MS > 0) ? $clog2(TIMEOUT_MS + 1) : 1;

    state_t              state, state_nxt;
    logic                ms_clr, ms_en, ms_tick;
    logic [TO_W-1:0]     to_cnt;
    logic [FREQ_W-1:0]   prd_lat;
    logic                div_issued, b2b_issued;
    logic                prd_acc, div_acc, b2b_acc, timeout;

    ms_tick_gen #(.CLK_MS_COUNT(CLK_MS_COUNT)) u_ms_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (ms_clr),
        .en    (ms_en),
        .tick  (ms_tick)
    );

    // Completion ticks only count once the matching start pulse has gone out.
    assign prd_acc = prd_done_tick && !prd_start;
    assign div_acc = div_done_tick && div_issued;
    assign b2b_acc = b2b_done_tick && b2b_issued;
    assign timeout = (to_cnt == TO_W'(TIMEOUT_MS));

    assign dvnd = DIV_W'(DVND);
    assign dvsr = {{(DIV_W - FREQ_W){1'b0}}, prd_lat};
    assign bin  = freq;

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start)     state_nxt = ARM;
            ARM:  if (prd_ready) state_nxt = MEAS;
            MEAS: begin
                if (prd_acc)
                    state_nxt = (prd == '0) ? CONV : DIV;
                else if (timeout)
                    state_nxt = DONE;
            end
            DIV:  if (div_acc)   state_nxt = CONV;
            CONV: if (b2b_acc)   state_nxt = DONE;
            DONE:                state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready     = (state == IDLE);
        done_tick = (state == DONE);
        ms_en     = (state == MEAS);
        ms_clr    = (state == ARM);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prd_start  <= 1'b0;
            div_start  <= 1'b0;
            b2b_start  <= 1'b0;
            div_issued <= 1'b0;
            b2b_issued <= 1'b0;
            to_cnt     <= '0;
            prd_lat    <= '0;
            freq       <= '0;
            freq_bcd   <= '0;
            err        <= 1'b0;
        end else begin
            prd_start  <= (state == ARM) && prd_ready;
            div_start  <= (state == DIV) && div_ready && !div_issued;
            div_issued <= (state == DIV) && (div_issued || div_ready);
            b2b_start  <= (state == CONV) && b2b_ready && !b2b_issued;
            b2b_issued <= (state == CONV) && (b2b_issued || b2b_ready);

            if (state == ARM)
                to_cnt <= '0;
            else if ((state == MEAS) && ms_tick && !timeout)
                to_cnt <= to_cnt + TO_W'(1);

            if ((state == IDLE) && start)
                err <= 1'b0;

            if (state == MEAS) begin
                if (prd_acc) begin
                    prd_lat <= prd;
                    if (prd == '0) begin
                        err  <= 1'b1;
                        freq <= '0;
                    end
                end else if (timeout) begin
                    err <= 1'b1;
                end
            end

            // Quotients beyond 10 bits saturate and flag an error.
            if ((state == DIV) && div_acc) begin
                if (quo[DIV_W-1:FREQ_W] != '0) begin
                    freq <= '1;
                    err  <= 1'b1;
                end else begin
                    freq <= quo[FREQ_W-1:0];
                end
            end

            if ((state == CONV) && b2b_acc)
                freq_bcd <= bcd;
        end
    end

endmodule

// File: tb/tb_auto_freq_ctrl.sv
// Directed bench for auto_freq_ctrl with the period counter, divider and
// BCD converter modelled by hand-driven handshakes.
module tb_auto_freq_ctrl;

    logic        clk = 1'b0;
    logic        reset, start;
    logic        prd_ready, prd_done_tick;
    logic [9:0]  prd;
    logic        prd_start;
    logic        div_ready, div_done_tick;
    logic [19:0] quo;
    logic        div_start;
    logic [19:0] dvsr, dvnd;
    logic        b2b_ready, b2b_done_tick;
    logic [15:0] bcd;
    logic        b2b_start;
    logic [9:0]  bin;
    logic        ready, done_tick, err;
    logic [9:0]  freq;
    logic [15:0] freq_bcd;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_done  = 0;
    int n_div   = 0;
    int n_prd   = 0;

    auto_freq_ctrl #(.CLK_MS_COUNT(4), .TIMEOUT_MS(3), .DVND(1000)) dut (
        .clk(clk), .reset(reset), .start(start),
        .prd_ready(prd_ready), .prd_done_tick(prd_done_tick), .prd(prd),
        .prd_start(prd_start),
        .div_ready(div_ready), .div_done_tick(div_done_tick), .quo(quo),
        .div_start(div_start), .dvsr(dvsr), .dvnd(dvnd),
        .b2b_ready(b2b_ready), .b2b_done_tick(b2b_done_tick), .bcd(bcd),
        .b2b_start(b2b_start), .bin(bin),
        .ready(ready), .done_tick(done_tick), .err(err),
        .freq(freq), .freq_bcd(freq_bcd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_tick) n_done++;
        if (div_start) n_div++;
        if (prd_start) n_prd++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            0: return prd_start;
            1: return div_start;
            2: return b2b_start;
            default: return done_tick;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sig_of(sel)) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 1);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_prd(input logic [9:0] v);
        prd = v; prd_done_tick = 1'b1;
        @(posedge clk); #1;
        prd_done_tick = 1'b0;
    endtask

    task automatic pulse_div(input logic [19:0] q);
        quo = q; div_done_tick = 1'b1;
        @(posedge clk); #1;
        div_done_tick = 1'b0;
    endtask

    task automatic pulse_b2b(input logic [15:0] b);
        bcd = b; b2b_done_tick = 1'b1;
        @(posedge clk); #1;
        b2b_done_tick = 1'b0;
    endtask

    initial begin
        int p_cyc, d_cyc, base_done, base_div, base_prd;
        logic any_start;

        reset = 1'b0; start = 1'b0;
        prd_ready = 1'b1; prd_done_tick = 1'b0; prd = '0;
        div_ready = 1'b1; div_done_tick = 1'b0; quo = '0;
        b2b_ready = 1'b1; b2b_done_tick = 1'b0; bcd = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_ready", 32'(ready), 1);
        check("rst_done", 32'(done_tick), 0);
        check("rst_err", 32'(err), 0);
        check("rst_freq", 32'(freq), 0);
        check("rst_bcd", 32'(freq_bcd), 0);
        check("rst_starts", {29'b0, prd_start, div_start, b2b_start}, 0);

        // normal measurement: prd=4 -> 1000/4 = 250
        do_start();
        wait_for(0, "t1_prd_start");
        @(negedge clk);
        pulse_prd(10'd4);
        wait_for(1, "t1_div_start");
        check("t1_dvsr", 32'(dvsr), 4);
        check("t1_dvnd", 32'(dvnd), 1000);
        @(negedge clk);
        pulse_div(20'd250);
        wait_for(2, "t1_b2b_start");
        check("t1_bin", 32'(bin), 250);
        check("t1_freq", 32'(freq), 250);
        @(negedge clk);
        pulse_b2b(16'h0250);
        wait_for(3, "t1_done");
        check("t1_freq_bcd", 32'(freq_bcd), 32'h0250);
        check("t1_err", 32'(err), 0);
        @(negedge clk);
        check("t1_done_1cyc", 32'(done_tick), 0);
        check("t1_ready_back", 32'(ready), 1);

        // zero period: divider skipped, freq forced to 0 with err
        base_div = n_div;
        do_start();
        wait_for(0, "t2_prd_start");
        @(negedge clk);
        pulse_prd(10'd0);
        wait_for(2, "t2_b2b_start");
        check("t2_bin", 32'(bin), 0);
        check("t2_freq", 32'(freq), 0);
        check("t2_err", 32'(err), 1);
        check("t2_no_div", 32'(n_div - base_div), 0);
        @(negedge clk);
        pulse_b2b(16'h0000);
        wait_for(3, "t2_done");

        // quotient overflow saturates; start during MEAS ignored
        do_start();
        wait_for(0, "t3_prd_start");
        check("t3_err_cleared", 32'(err), 0);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        pulse_prd(10'd1);
        wait_for(1, "t3_div_start");
        check("t3_dvsr", 32'(dvsr), 1);
        @(negedge clk);
        pulse_div(20'h00400);
        wait_for(2, "t3_b2b_start");
        check("t3_freq_sat", 32'(freq), 32'h3FF);
        check("t3_err", 32'(err), 1);
        @(negedge clk);
        pulse_b2b(16'h1023);
        wait_for(3, "t3_done");
        check("t3_freq_bcd", 32'(freq_bcd), 32'h1023);
        repeat (3) @(negedge clk);
        check("t3_idle", 32'(ready), 1);

        // timeout: 3 ms of 4 cycles, done one cycle after the last wrap
        base_div = n_div;
        do_start();
        wait_for(0, "t4_prd_start");
        p_cyc = cyc;
        wait_for(3, "t4_done");
        d_cyc = cyc;
        check("t4_latency", 32'(d_cyc - p_cyc), 13);
        check("t4_err", 32'(err), 1);
        check("t4_freq_kept", 32'(freq), 32'h3FF);
        check("t4_bcd_kept", 32'(freq_bcd), 32'h1023);
        check("t4_no_div", 32'(n_div - base_div), 0);

        // ARM waits for prd_ready; one prd_start when it rises
        prd_ready = 1'b0;
        base_prd = n_prd;
        do_start();
        any_start = 1'b0;
        repeat (10) begin
            @(negedge clk);
            any_start = any_start | prd_start;
        end
        check("t5_no_prd_start", 32'(any_start), 0);
        prd_ready = 1'b1;
        wait_for(0, "t5_prd_start");
        @(negedge clk);
        pulse_prd(10'd5);
        wait_for(1, "t5_div_start");
        @(negedge clk);
        pulse_div(20'd200);
        wait_for(2, "t5_b2b_start");
        @(negedge clk);
        pulse_b2b(16'h0200);
        wait_for(3, "t5_done");
        check("t5_prd_once", 32'(n_prd - base_prd), 1);
        check("t5_freq", 32'(freq), 200);
        check("t5_err", 32'(err), 0);

        // reset during DIV aborts without done_tick
        div_ready = 1'b0;
        base_div = n_div;
        do_start();
        wait_for(0, "t6_prd_start");
        @(negedge clk);
        pulse_prd(10'd8);
        repeat (3) @(negedge clk);
        check("t6_dvsr", 32'(dvsr), 8);
        base_done = n_done;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("t6_ready", 32'(ready), 1);
        check("t6_no_done", 32'(done_tick), 0);
        check("t6_freq_rst", 32'(freq), 0);
        div_ready = 1'b1;
        pulse_div(20'd125);
        repeat (6) @(negedge clk);
        check("t6_still_idle", 32'(ready), 1);
        check("t6_no_div_start", 32'(n_div - base_div), 0);
        check("t6_no_done_later", 32'(n_done - base_done), 0);
        check("t6_freq_kept", 32'(freq), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/auto_freq_ctrl.md
AUTO_FREQ_CTRL -- requirements
Module: auto_freq_ctrl

Interface
REQ-001 Parameters (name, default, meaning): CLK_MS_COUNT, 50000, clk cycles per 1 ms tick; TIMEOUT_MS, 2000, max ms to wait for a period result; DVND, 1000, dividend (ms per s) for freq = DVND/prd.
REQ-002 clk  in  1  single system clock; all logic on posedge clk.
REQ-003 reset  in  1  synchronous, active-low reset (reset=0 resets on the next posedge clk).
REQ-004 start  in  1  request one measurement; sampled only in IDLE.
REQ-005 prd_ready, prd_done_tick  in  1 each  period-counter ready level / completion pulse.
REQ-006 prd  in  10  measured period in ms, valid on prd_done_tick.
REQ-007 prd_start  out  1  one-cycle start pulse to the period counter.
REQ-008 div_ready, div_done_tick  in  1 each  divider ready level / completion pulse.
REQ-009 quo  in  20  divider quotient, valid on div_done_tick.
REQ-010 div_start  out  1; dvsr, dvnd  out  20 each  divider start pulse and operands.
REQ-011 b2b_ready, b2b_done_tick  in  1 each; bcd  in  16  binary-to-BCD handshake and result.
REQ-012 b2b_start  out  1; bin  out  10  BCD-converter start pulse and operand.
REQ-013 ready, done_tick, err  out  1 each; freq  out  10; freq_bcd  out  16  status and results.

Function
REQ-014 States: IDLE, ARM, MEAS, DIV, CONV, DONE; encoding 3 bits.
REQ-015 IDLE: ready=1; start=1 -> ARM, clear err; start ignored in all other states.
REQ-016 ARM: wait for prd_ready=1; on that cycle pulse prd_start for exactly 1 cycle, clear ms counter and timeout counter, -> MEAS.
REQ-017 MEAS: ms counter counts 0..CLK_MS_COUNT-1 and wraps; each wrap increments timeout counter (width ceil(log2(TIMEOUT_MS+1)) bits, no wrap).
REQ-018 MEAS, prd_done_tick=1: latch prd; prd=0 -> err=1, freq=0, -> CONV with bin=0; prd>0 -> DIV.
REQ-019 MEAS, timeout counter == TIMEOUT_MS and no prd_done_tick that cycle -> err=1, freq and freq_bcd unchanged, -> DONE; prd_done_tick wins if both occur in the same cycle.
REQ-020 DIV: dvnd=DVND, dvsr={10'b0,prd_latched} held stable; div_start pulses 1 cycle on first cycle div_ready=1; on div_done_tick latch freq=quo[9:0] (quo[19:10]!=0 -> freq=10'h3FF, err=1), -> CONV.
REQ-021 CONV: bin=freq held stable; b2b_start pulses 1 cycle on first cycle b2b_ready=1; on b2b_done_tick latch freq_bcd=bcd, -> DONE.
REQ-022 DONE: done_tick=1 for exactly 1 cycle, -> IDLE.
REQ-023 Each start pulse (prd_start, div_start, b2b_start) is issued at most once per state visit; done ticks arriving before the corresponding start pulse are ignored.
REQ-024 Latency from prd_done_tick to done_tick = divider latency + converter latency + handshake waits + 2 cycles.
REQ-025 After a timeout the period counter may still be armed; the next measurement issues prd_start only when prd_ready returns to 1 (ARM waits indefinitely).
REQ-026 ready, done_tick, prd_start, div_start, b2b_start are registered-state decodes; no combinational path from any input to them.

Reset
REQ-027 reset=0: state=IDLE, ms/timeout counters=0, latched prd=0, freq=0, freq_bcd=0, err=0, all start pulses and done_tick=0, ready=1 on the following cycle.
REQ-028 reset=0 in any state aborts the sequence with no done_tick; reset overrides all inputs in the same cycle.

Structure
REQ-029 Shared package auto_freq_pkg holds the state encoding, CLK_MS_COUNT and DVND defaults, and result widths (10, 16, 20).
REQ-030 One sub-module, ms_tick_gen (ms counter plus tick output, clear input), is instantiated; FSM and result registers are in auto_freq_ctrl.

Verification
REQ-031 CLK_MS_COUNT=4, model sub-blocks; start, prd=4 -> div sees dvsr=4, dvnd=1000; quo=250 -> freq=250, freq_bcd=16'h0250, done_tick 1 cycle, err=0.
REQ-032 prd=0 on prd_done_tick -> no div_start, b2b bin=0, freq=0, err=1, done_tick pulses.
REQ-033 TIMEOUT_MS=3, CLK_MS_COUNT=4, no prd_done_tick -> done_tick exactly 12 cycles after prd_start cycle (+-1 per REQ-019), err=1, freq unchanged.
REQ-034 prd_ready held 0 for 10 cycles in ARM -> prd_start stays 0, then pulses exactly once when prd_ready rises.
REQ-035 reset=0 asserted during DIV -> next cycle state IDLE, ready=1, no done_tick, later div_done_tick ignored.
REQ-036 quo=20'h00400 -> freq=10'h3FF, err=1; start pulsed during MEAS -> no effect on sequence.
